// File: rtl/farm_scheduler.sv
// Shared farm-bus sequencer: dispatches jobs to idle SHA units and collects finished
// results, with independent round-robin pointers and collection taking priority.
module farm_scheduler #(
    parameter int unsigned WIDTH_BITS   = 5,
    parameter int unsigned NUM_ROWS     = 4,
    parameter int unsigned NUM_COLS     = 4,
    parameter int unsigned LOAD_BEATS   = 4,
    parameter int unsigned UNLOAD_BEATS = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           job_valid_i,
    output logic                           job_ready_o,
    input  logic [NUM_ROWS*NUM_COLS-1:0]   unit_busy_i,
    input  logic [NUM_ROWS*NUM_COLS-1:0]   unit_done_i,
    input  logic                           farmbusy_i,
    output logic                           duwrite_o,
    output logic                           rd_active_o,
    output logic                           start_o,
    output logic                           done_ack_o,
    output logic [WIDTH_BITS-1:0]          writerow_en_o,
    output logic [WIDTH_BITS-1:0]          writecol_en_o,
    output logic [WIDTH_BITS-1:0]          readrow_en_o,
    output logic [WIDTH_BITS-1:0]          readcol_en_o
);

    localparam int unsigned N         = NUM_ROWS * NUM_COLS;
    localparam int unsigned IDX_W     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MAX_BEATS = (LOAD_BEATS > UNLOAD_BEATS) ? LOAD_BEATS : UNLOAD_BEATS;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_BEATS - 1);
    localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(UNLOAD_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_UNLOAD,
        S_ACK
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_wr_ptr;
    logic [IDX_W-1:0]      r_rd_ptr;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [IDX_W-1:0]      r_rd_idx;
    logic                  r_job_ready;
    logic                  r_duwrite;
    logic                  r_rd_active;
    logic                  r_start;
    logic                  r_done_ack;
    logic [WIDTH_BITS-1:0] r_writerow;
    logic [WIDTH_BITS-1:0] r_writecol;
    logic [WIDTH_BITS-1:0] r_readrow;
    logic [WIDTH_BITS-1:0] r_readcol;

    logic [N-1:0]          w_free;
    logic [IDX_W:0]        w_rd_pick;
    logic [IDX_W:0]        w_wr_pick;

    // Index base+step modulo N; step never exceeds N so one subtraction suffices.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned      step);
        int unsigned sum;
        sum = 32'(base) + step;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IDX_W'(sum);
    endfunction

    // First requester after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0]     req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] pos;
        res = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = wrap_idx(ptr, k);
            if (!res[IDX_W] && req[pos]) begin
                res = {1'b1, pos};
            end
        end
        return res;
    endfunction

    function automatic logic [WIDTH_BITS-1:0] idx_row(input logic [IDX_W-1:0] idx);
        return WIDTH_BITS'(32'(idx) / NUM_COLS);
    endfunction

    function automatic logic [WIDTH_BITS-1:0] idx_col(input logic [IDX_W-1:0] idx);
        return WIDTH_BITS'(32'(idx) % NUM_COLS);
    endfunction

    always_comb begin
        w_free    = ~unit_busy_i & ~unit_done_i;
        w_rd_pick = rr_pick(unit_done_i, r_rd_ptr);
        w_wr_pick = rr_pick(w_free, r_wr_ptr);
    end

    // Sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wr_ptr    <= LAST_IDX;
            r_rd_ptr    <= LAST_IDX;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_job_ready <= 1'b0;
            r_duwrite   <= 1'b0;
            r_rd_active <= 1'b0;
            r_start     <= 1'b0;
            r_done_ack  <= 1'b0;
            r_writerow  <= '0;
            r_writecol  <= '0;
            r_readrow   <= '0;
            r_readcol   <= '0;
        end else begin
            r_job_ready <= 1'b0;
            r_start     <= 1'b0;
            r_done_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_pick[IDX_W]) begin
                        r_rd_idx    <= w_rd_pick[IDX_W-1:0];
                        r_readrow   <= idx_row(w_rd_pick[IDX_W-1:0]);
                        r_readcol   <= idx_col(w_rd_pick[IDX_W-1:0]);
                        r_cnt       <= '0;
                        r_rd_active <= 1'b1;
                        r_state     <= S_UNLOAD;
                    end else if (job_valid_i && w_wr_pick[IDX_W]) begin
                        r_wr_idx    <= w_wr_pick[IDX_W-1:0];
                        r_writerow  <= idx_row(w_wr_pick[IDX_W-1:0]);
                        r_writecol  <= idx_col(w_wr_pick[IDX_W-1:0]);
                        r_cnt       <= '0;
                        r_job_ready <= 1'b1;
                        r_duwrite   <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!farmbusy_i) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LOAD_LAST) begin
                            r_duwrite <= 1'b0;
                            r_start   <= 1'b1;
                            r_state   <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_wr_ptr <= r_wr_idx;
                    r_state  <= S_IDLE;
                end
                S_UNLOAD: begin
                    if (!farmbusy_i) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == UNLOAD_LAST) begin
                            r_rd_active <= 1'b0;
                            r_done_ack  <= 1'b1;
                            r_state     <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    r_rd_ptr <= r_rd_idx;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ready_o   = r_job_ready;
    assign duwrite_o     = r_duwrite;
    assign rd_active_o   = r_rd_active;
    assign start_o       = r_start;
    assign done_ack_o    = r_done_ack;
    assign writerow_en_o = r_writerow;
    assign writecol_en_o = r_writecol;
    assign readrow_en_o  = r_readrow;
    assign readcol_en_o  = r_readcol;

endmodule

// File: tb/tb_farm_scheduler.sv
// Bench for farm_scheduler: random farm traffic against a transaction-level model,
// then directed farm-full/stall, priority and reset-abort scenarios.
module tb_farm_scheduler;

    localparam int WB   = 5;
    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int LB   = 4;
    localparam int UB   = 2;
    localparam int N    = NR * NC;
    localparam int NCYC = 800;
    localparam int ASZ  = NCYC + 256;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          job_valid_i = 1'b0;
    logic          job_ready_o;
    logic [N-1:0]  unit_busy_i = '0;
    logic [N-1:0]  unit_done_i = '0;
    logic          farmbusy_i = 1'b0;
    logic          duwrite_o;
    logic          rd_active_o;
    logic          start_o;
    logic          done_ack_o;
    logic [WB-1:0] writerow_en_o;
    logic [WB-1:0] writecol_en_o;
    logic [WB-1:0] readrow_en_o;
    logic [WB-1:0] readcol_en_o;

    farm_scheduler #(
        .WIDTH_BITS  (WB),
        .NUM_ROWS    (NR),
        .NUM_COLS    (NC),
        .LOAD_BEATS  (LB),
        .UNLOAD_BEATS(UB)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .job_valid_i  (job_valid_i),
        .job_ready_o  (job_ready_o),
        .unit_busy_i  (unit_busy_i),
        .unit_done_i  (unit_done_i),
        .farmbusy_i   (farmbusy_i),
        .duwrite_o    (duwrite_o),
        .rd_active_o  (rd_active_o),
        .start_o      (start_o),
        .done_ack_o   (done_ack_o),
        .writerow_en_o(writerow_en_o),
        .writecol_en_o(writecol_en_o),
        .readrow_en_o (readrow_en_o),
        .readcol_en_o (readcol_en_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse vector order: {job_ready, duwrite, rd_active, start, done_ack}
    function automatic logic [31:0] obs_pulse();
        return {27'b0, job_ready_o, duwrite_o, rd_active_o, start_o, done_ack_o};
    endfunction

    function automatic logic [31:0] obs_sel();
        return {12'b0, writerow_en_o, writecol_en_o, readrow_en_o, readcol_en_o};
    endfunction

    // Expected per-cycle waveform, filled a whole transaction at a time.
    bit          jv[ASZ];
    bit          st[ASZ];
    logic [4:0]  e_pulse[ASZ];
    logic [19:0] e_sel[ASZ];

    int m_rd_ptr, m_wr_ptr, m_idle;
    int m_wrow, m_wcol, m_rrow, m_rcol;

    logic [N-1:0] env_busy, env_done;
    int fin[N];
    int busy_at[N];
    int ack_at[N];

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_exp(input int t, input logic [4:0] p);
        if (t < ASZ) begin
            e_pulse[t] = p;
            e_sel[t]   = {5'(m_wrow), 5'(m_wcol), 5'(m_rrow), 5'(m_rcol)};
        end
    endtask

    task automatic env_update(input int c);
        for (int u = 0; u < N; u++) begin
            if (busy_at[u] == c) begin
                env_busy[u] = 1'b1;
                fin[u] = c + int'($urandom_range(2, 40));
            end
            if (env_busy[u] && fin[u] == c) begin
                env_busy[u] = 1'b0;
                env_done[u] = 1'b1;
            end
            if (ack_at[u] == c) env_done[u] = 1'b0;
        end
    endtask

    task automatic decide(input int c);
        int rd, wr, t, beats;
        rd = pick(env_done, m_rd_ptr);
        wr = pick(~env_busy & ~env_done, m_wr_ptr);
        if (rd >= 0) begin
            m_rrow = rd / NC;
            m_rcol = rd % NC;
            t = c;
            beats = 0;
            while (beats < UB) begin
                t++;
                set_exp(t, 5'b00100);
                if (!st[t]) beats++;
            end
            set_exp(t + 1, 5'b00001);
            ack_at[rd] = t + 2;
            m_rd_ptr = rd;
            m_idle = t + 2;
        end else if (jv[c] && wr >= 0) begin
            m_wrow = wr / NC;
            m_wcol = wr % NC;
            t = c;
            beats = 0;
            while (beats < LB) begin
                t++;
                set_exp(t, (t == c + 1) ? 5'b11000 : 5'b01000);
                if (!st[t]) beats++;
            end
            set_exp(t + 1, 5'b00010);
            busy_at[wr] = t + 2;
            m_wr_ptr = wr;
            m_idle = t + 2;
        end else begin
            m_idle = c + 1;
        end
        set_exp(m_idle, 5'b00000);
    endtask

    int n_dw;

    initial begin
        for (int i = 0; i < ASZ; i++) begin
            jv[i] = ($urandom_range(0, 9) < 7);
            st[i] = ($urandom_range(0, 3) == 0);
            e_pulse[i] = 'x;
            e_sel[i]   = 'x;
        end
        jv[0] = 1'b1;
        for (int i = 1; i <= 5; i++) st[i] = 1'b0;
        for (int u = 0; u < N; u++) begin
            fin[u] = -1;
            busy_at[u] = -1;
            ack_at[u] = -1;
        end
        env_busy = '0;
        env_done = '0;
        m_rd_ptr = N - 1;
        m_wr_ptr = N - 1;
        m_idle = 0;
        m_wrow = 0; m_wcol = 0; m_rrow = 0; m_rcol = 0;
        set_exp(0, 5'b00000);

        repeat (3) @(posedge clk_i);
        #1;
        check("reset pulses", obs_pulse(), 32'd0);
        check("reset sels", obs_sel(), 32'd0);
        rst_i = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < NCYC; c++) begin
            check($sformatf("c%0d pulses", c), obs_pulse(), 32'(e_pulse[c]));
            check($sformatf("c%0d sels", c), obs_sel(), 32'(e_sel[c]));
            env_update(c);
            job_valid_i = jv[c];
            farmbusy_i  = st[c];
            unit_busy_i = env_busy;
            unit_done_i = env_done;
            if (c == m_idle) decide(c);
            @(posedge clk_i);
            #1;
        end

        // Asynchronous reset from wherever the random run stopped.
        rst_i = 1'b0;
        job_valid_i = 1'b0;
        farmbusy_i = 1'b0;
        unit_busy_i = '0;
        unit_done_i = '0;
        #1;
        check("async rst pulses", obs_pulse(), 32'd0);
        check("async rst sels", obs_sel(), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Farm full: no acceptance until unit 9 frees up.
        unit_busy_i = '1;
        job_valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("full%0d", k), {30'b0, job_ready_o, duwrite_o}, 32'd0);
        end
        unit_busy_i[9] = 1'b0;
        @(posedge clk_i);
        #1;
        check("full ready", obs_pulse(), 32'(5'b11000));
        check("full wsel", {22'b0, writerow_en_o, writecol_en_o}, {22'b0, 5'd2, 5'd1});
        job_valid_i = 1'b0;

        // Three stalled beats stretch the load to 7 cycles.
        n_dw = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!duwrite_o) break;
            n_dw++;
            farmbusy_i = (k >= 2 && k <= 4);
            @(posedge clk_i);
            #1;
        end
        farmbusy_i = 1'b0;
        check("stall duwrite len", 32'(n_dw), 32'd7);
        check("stall start", {31'b0, start_o}, 32'd1);
        unit_busy_i[9] = 1'b1;

        // Collection beats dispatch; reset mid-unload aborts it.
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        unit_busy_i = '0;
        unit_done_i = 16'h0020;
        job_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("prio u1", obs_pulse(), 32'(5'b00100));
        check("prio rsel", {22'b0, readrow_en_o, readcol_en_o}, {22'b0, 5'd1, 5'd1});
        @(posedge clk_i);
        #1;
        check("prio u2", obs_pulse(), 32'(5'b00100));
        rst_i = 1'b0;
        #1;
        check("abort pulses", obs_pulse(), 32'd0);
        check("abort sels", obs_sel(), 32'd0);
        @(posedge clk_i);
        #1;
        check("abort held", obs_pulse(), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("recollect u1", obs_pulse(), 32'(5'b00100));
        check("recollect rsel", {22'b0, readrow_en_o, readcol_en_o}, {22'b0, 5'd1, 5'd1});
        @(posedge clk_i);
        #1;
        check("recollect u2", obs_pulse(), 32'(5'b00100));
        @(posedge clk_i);
        #1;
        check("recollect ack", obs_pulse(), 32'(5'b00001));
        unit_done_i = '0;
        @(posedge clk_i);
        #1;
        check("post ack idle", obs_pulse(), 32'd0);
        @(posedge clk_i);
        #1;
        check("then dispatch", obs_pulse(), 32'(5'b11000));
        check("then wsel", {22'b0, writerow_en_o, writecol_en_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/farm_scheduler.md
Name: farm_scheduler

Overview:
- Sequences the distribution unit's shared farm bus between the units of the SHA farm grid.
- Dispatches each job from memory to an idle unit, and collects finished results from units reporting done.
- Drives the encoded write/read row/column selects and the duwrite handshake that the distribution unit uses to steer data.
- Round-robin fairness applies separately to dispatch and to collection; result collection has priority over new dispatch.

Parameters:
- WIDTH_BITS, 5, width of each encoded row/column select.
- NUM_ROWS, 4, farm rows (at most 2^WIDTH_BITS).
- NUM_COLS, 4, farm columns (at most 2^WIDTH_BITS).
- LOAD_BEATS, 4, bus beats per job load (at least 1).
- UNLOAD_BEATS, 2, bus beats per result unload (at least 1).

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-low reset.
- job_valid_i, in, 1, memory side has a job pending.
- job_ready_o, out, 1, one-cycle pulse: job accepted.
- unit_busy_i, in, NUM_ROWS*NUM_COLS, per-unit busy; index = row*NUM_COLS+col.
- unit_done_i, in, NUM_ROWS*NUM_COLS, per-unit result ready.
- farmbusy_i, in, 1, farm bus stall; a beat does not advance while high.
- duwrite_o, out, 1, load beat in progress (distribution unit reads memory).
- rd_active_o, out, 1, unload beat in progress.
- start_o, out, 1, one-cycle pulse: selected write unit begins hashing.
- done_ack_o, out, 1, one-cycle pulse: selected read unit's result consumed.
- writerow_en_o, out, WIDTH_BITS, encoded row of the dispatch target.
- writecol_en_o, out, WIDTH_BITS, encoded column of the dispatch target.
- readrow_en_o, out, WIDTH_BITS, encoded row of the collect target.
- readcol_en_o, out, WIDTH_BITS, encoded column of the collect target.

Behaviour:
- Reset (rst_i low, asynchronous):
  - FSM enters IDLE; all 1-bit outputs are 0; all row/column selects are 0.
  - Both round-robin pointers are set to N-1 (N = NUM_ROWS*NUM_COLS), so the first search starts at unit 0.
  - Reset mid-LOAD or mid-UNLOAD aborts the operation; no start_o or done_ack_o is issued.
- FSM states are IDLE, LOAD, START, UNLOAD, ACK.
- IDLE:
  - If any unit_done_i bit is set, the collect target is the first set bit searching upward from rd_ptr+1, wrapping modulo N.
    - read row/col are registered from the target: row = idx / NUM_COLS, col = idx % NUM_COLS.
    - Next state is UNLOAD.
  - Otherwise, if job_valid_i is high and any unit is free (busy=0 and done=0), the dispatch target is the first free unit searching upward from wr_ptr+1, wrapping.
    - write row/col are registered from the target.
    - job_ready_o pulses in the same cycle.
    - Next state is LOAD.
  - Otherwise the FSM stays in IDLE. job_ready_o stays 0 when no unit is free, even with job_valid_i high.
- LOAD:
  - duwrite_o is 1.
  - The beat counter increments on each cycle with farmbusy_i=0.
  - After LOAD_BEATS counted beats, the next state is START.
- START:
  - start_o pulses for 1 cycle; wr_ptr takes the dispatched index.
  - Next state is IDLE.
- UNLOAD:
  - rd_active_o is 1.
  - The beat counter counts UNLOAD_BEATS non-stalled cycles, then the next state is ACK.
- ACK:
  - done_ack_o pulses for 1 cycle; rd_ptr takes the collected index.
  - Next state is IDLE.
- Select holding: row/column selects hold their last value outside their own operation and change only in IDLE on a new selection.
- Unit contract:
  - A unit raises busy in the cycle after start_o.
  - A unit drops done in the cycle after done_ack_o.
  - The IDLE cycle following START/ACK therefore sees updated status, and no unit is selected twice.
- Latency:
  - Dispatch with no stalls: IDLE + LOAD_BEATS + START = LOAD_BEATS+2 cycles.
  - Collect with no stalls: UNLOAD_BEATS+2 cycles.
- A simultaneous done and job_valid in IDLE resolves to collection first; the job waits.
- The beat counter is ceil(log2(max(LOAD_BEATS, UNLOAD_BEATS)+1)) bits wide and clears on entry to LOAD or UNLOAD.
- unit_busy_i and unit_done_i are not sampled during LOAD, START, UNLOAD or ACK.

Test Plan:
- Reset then idle: all units free, job_valid_i=1 → job_ready_o pulses; writerow=0, writecol=0; duwrite_o high for 4 cycles; start_o pulses at cycle 6.
- Round robin: units 0-2 busy after successive dispatches, job_valid held high → targets are (0,0), (0,1), (0,2), (0,3), then (1,0); unit 15 free → wraps to (0,0) after unit 15.
- Priority: unit_done_i[5]=1 with job_valid_i=1 in the same IDLE cycle → UNLOAD first with readrow=1, readcol=1; rd_active 2 cycles; done_ack_o pulse; then dispatch.
- Stall: farmbusy_i high for 3 cycles mid-LOAD → duwrite_o stays high for 7 cycles total; start_o is delayed 3 cycles.
- Farm full: all unit_busy_i=1, job_valid_i=1 → job_ready_o stays 0 for 20 cycles; dropping busy[9] → dispatch to row 2, col 1.
- Reset mid-UNLOAD: rst_i low during the second beat → all outputs are 0 at once; no done_ack_o; after release, done[5] still set → re-collected from unit 5.
